// File: rtl/zeroriscy_dsram_arb.sv
// zeroriscy_dsram_arb: one-access-per-cycle arbiter between a 32-bit core port and a 256-bit-row accelerator burst port.
// Define DSRAM_ARB_RR_EN for round-robin sharing under contention during bursts; otherwise the core has strict priority.
module zeroriscy_dsram_arb #(
    parameter int ROW_AW = 12,
    parameter int LEN_W  = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              p_req,
    input  logic              p_we,
    input  logic [3:0]        p_be,
    input  logic [31:0]       p_addr,
    input  logic [31:0]       p_wdata,
    output logic              p_gnt,
    output logic              p_rvalid,
    output logic [31:0]       p_rdata,
    input  logic              a_req,
    input  logic [ROW_AW-1:0] a_addr,
    input  logic [LEN_W-1:0]  a_len,
    output logic              a_gnt,
    output logic              a_rvalid,
    output logic [255:0]      a_rdata,
    output logic              a_done,
    output logic [ROW_AW-1:0] r_addr,
    output logic [7:0]        r_cs,
    output logic              r_we,
    output logic [3:0]        r_be,
    output logic [31:0]       r_din,
    input  logic [255:0]      r_dout
);
    typedef enum logic {IDLE, BURST} state_t;
    state_t state, state_nx;
    logic [ROW_AW-1:0] row;
    logic [LEN_W:0] beats;
    logic core, beat, p_rv, a_rv, a_last;
    logic [2:0] lane;
    logic unused_addr_bits;
    assign unused_addr_bits = ^{p_addr[31:ROW_AW+5], p_addr[1:0]};
`ifdef DSRAM_ARB_RR_EN
    logic acc_last;
`endif
    always_comb begin
        state_nx = state;
        core = 1'b0;
        beat = 1'b0;
        a_gnt = 1'b0;
        if (!reset) begin
            if (state == IDLE) begin
                core = p_req;
                a_gnt = a_req;
                state_nx = a_req ? BURST : IDLE;
            end else begin
`ifdef DSRAM_ARB_RR_EN
                beat = !p_req || !acc_last;
`else
                beat = !p_req;
`endif
                core = p_req && !beat;
                state_nx = (beat && beats == (LEN_W+1)'(1)) ? IDLE : BURST;
            end
        end
    end
    assign p_gnt = core;
    assign r_addr = core ? p_addr[ROW_AW+4:5] : beat ? row : '0;
    assign r_cs = core ? (8'h01 << p_addr[4:2]) : beat ? 8'hFF : 8'h00;
    assign r_we = core && p_we;
    assign r_be = core ? p_be : 4'h0;
    assign r_din = core ? p_wdata : 32'h0;
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            row <= '0;
            beats <= '0;
            p_rv <= 1'b0;
            a_rv <= 1'b0;
            a_last <= 1'b0;
            lane <= '0;
        end else begin
            state <= state_nx;
            p_rv <= core;
            a_rv <= beat;
            a_last <= beat && beats == (LEN_W+1)'(1);
            if (core) lane <= p_addr[4:2];
            if (a_gnt) begin
                row <= a_addr;
                beats <= (LEN_W+1)'(a_len) + (LEN_W+1)'(1);
            end else if (beat) begin
                row <= row + ROW_AW'(1);
                beats <= beats - (LEN_W+1)'(1);
            end
        end
    end
`ifdef DSRAM_ARB_RR_EN
    // Winner memory only moves on contended burst cycles; each new burst starts favouring the accelerator.
    always_ff @(posedge clk) begin
        if (reset || a_gnt) acc_last <= 1'b0;
        else if (state == BURST && p_req) acc_last <= beat;
    end
`endif
    // Gating with reset suppresses responses of beats still in flight when reset hits.
    assign p_rvalid = p_rv && !reset;
    assign p_rdata = p_rvalid ? r_dout[{lane, 5'd0} +: 32] : 32'h0;
    assign a_rvalid = a_rv && !reset;
    assign a_rdata = a_rvalid ? r_dout : 256'h0;
    assign a_done = a_rvalid && a_last;
endmodule

// File: tb/tb_zeroriscy_dsram_arb.sv
// tb_zeroriscy_dsram_arb: directed and random traffic against a queue-based reference of the arbiter.
module tb_zeroriscy_dsram_arb;
    localparam int ROW_AW = 12;
    localparam int LEN_W = 8;
    localparam int NW = 1 << (ROW_AW + 3);
    logic clk = 1'b0;
    logic reset = 1'b1;
    logic p_req = 1'b0, p_we = 1'b0, a_req = 1'b0;
    logic [3:0] p_be = '0;
    logic [31:0] p_addr = '0, p_wdata = '0;
    logic [ROW_AW-1:0] a_addr = '0;
    logic [LEN_W-1:0] a_len = '0;
    logic p_gnt, p_rvalid, a_gnt, a_rvalid, a_done, r_we;
    logic [31:0] p_rdata, r_din;
    logic [255:0] a_rdata, r_dout;
    logic [ROW_AW-1:0] r_addr;
    logic [7:0] r_cs;
    logic [3:0] r_be;
    always #5 clk = ~clk;
    zeroriscy_dsram_arb #(.ROW_AW(ROW_AW), .LEN_W(LEN_W)) dut (
        .clk(clk), .reset(reset),
        .p_req(p_req), .p_we(p_we), .p_be(p_be), .p_addr(p_addr), .p_wdata(p_wdata),
        .p_gnt(p_gnt), .p_rvalid(p_rvalid), .p_rdata(p_rdata),
        .a_req(a_req), .a_addr(a_addr), .a_len(a_len),
        .a_gnt(a_gnt), .a_rvalid(a_rvalid), .a_rdata(a_rdata), .a_done(a_done),
        .r_addr(r_addr), .r_cs(r_cs), .r_we(r_we), .r_be(r_be), .r_din(r_din), .r_dout(r_dout)
    );
    function automatic logic [31:0] pat(input int idx);
        return (idx * 32'h9E3779B9) ^ 32'hA5A50000;
    endfunction
    // SRAM: unwritten words read as a fixed pattern, so no preload is needed.
    logic [31:0] sw [0:NW-1];
    bit sv [0:NW-1];
    logic [ROW_AW+2:0] sidx;
    logic [31:0] sword;
    always @(posedge clk) begin
        for (int l = 0; l < 8; l++) begin
            sidx = {r_addr, 3'(l)};
            sword = sv[sidx] ? sw[sidx] : pat(int'(sidx));
            r_dout[l*32 +: 32] <= sword;
            if (r_cs[l] && r_we) begin
                for (int b = 0; b < 4; b++) if (r_be[b]) sword[b*8 +: 8] = r_din[b*8 +: 8];
                sw[sidx] <= sword;
                sv[sidx] <= 1'b1;
            end
        end
    end
    int n_cmp = 0, n_bad = 0;
    task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask
    logic [31:0] rmem [0:NW-1];
    logic [ROW_AW-1:0] q[$];
    bit acc_won, e_prv, e_arv, e_done, last_agnt;
    logic [31:0] e_prdata;
    logic [255:0] e_ardata;
    function automatic logic [255:0] ref_row(input logic [ROW_AW-1:0] r);
        logic [255:0] v;
        for (int l = 0; l < 8; l++) v[l*32 +: 32] = rmem[{r, 3'(l)}];
        return v;
    endfunction
    task automatic step(input bit rst, input bit preq, input bit pwe, input logic [3:0] pbe,
                        input logic [31:0] paddr, input logic [31:0] pwdata,
                        input bit areq, input logic [ROW_AW-1:0] aaddr, input logic [LEN_W-1:0] alen);
        bit core, beat, agnt;
        logic [7:0] cs;
        logic [ROW_AW+2:0] widx;
        @(negedge clk);
        reset = rst; p_req = preq; p_we = pwe; p_be = pbe; p_addr = paddr; p_wdata = pwdata;
        a_req = areq; a_addr = aaddr; a_len = alen;
        #1;
        agnt = !rst && areq && q.size() == 0;
        beat = 1'b0;
        if (!rst && q.size() > 0) begin
`ifdef DSRAM_ARB_RR_EN
            beat = !preq || !acc_won;
`else
            beat = !preq;
`endif
        end
        core = !rst && preq && !beat;
        cs = '0;
        if (core) cs[paddr[4:2]] = 1'b1;
        if (beat) cs = 8'hFF;
        chk("p_gnt", p_gnt, core);
        chk("a_gnt", a_gnt, agnt);
        chk("r_cs", r_cs, cs);
        chk("r_we", r_we, core && pwe);
        chk("r_be", r_be, core ? pbe : 4'h0);
        chk("r_din", r_din, core ? pwdata : 32'h0);
        if (rst || core || beat) chk("r_addr", r_addr, rst ? '0 : core ? paddr[ROW_AW+4:5] : q[0]);
        chk("p_rvalid", p_rvalid, !rst && e_prv);
        chk("a_rvalid", a_rvalid, !rst && e_arv);
        chk("a_done", a_done, !rst && e_done);
        if (rst || e_prv) chk("p_rdata", p_rdata, rst ? 32'h0 : e_prdata);
        if (rst || e_arv) chk("a_rdata", a_rdata, rst ? 256'h0 : e_ardata);
        last_agnt = agnt;
        if (rst) begin
            q.delete();
            acc_won = 0; e_prv = 0; e_arv = 0; e_done = 0;
        end else begin
            e_prv = core; e_arv = beat; e_done = 0;
            if (core) begin
                widx = paddr[ROW_AW+4:2];
                e_prdata = rmem[widx];
                if (pwe) for (int b = 0; b < 4; b++) if (pbe[b]) rmem[widx][b*8 +: 8] = pwdata[b*8 +: 8];
            end
            if (q.size() > 0 && preq) acc_won = beat;
            if (beat) begin
                e_ardata = ref_row(q[0]);
                e_done = q.size() == 1;
                void'(q.pop_front());
            end
            if (agnt) begin
                acc_won = 0;
                for (int i = 0; i <= int'(alen); i++) q.push_back(aaddr + ROW_AW'(i));
            end
        end
    endtask
    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 4'h0, 32'h0, 32'h0, 0, '0, '0);
    endtask
    task automatic core_hold(input int n);
        for (int i = 0; i < n; i++) step(0, 1, 0, 4'hF, 32'h0000_0048, 32'h0, 0, '0, '0);
    endtask
    initial begin
        bit pend;
        logic [ROW_AW-1:0] aa;
        logic [LEN_W-1:0] al;
        logic [31:0] pa;
        for (int i = 0; i < NW; i++) rmem[i] = pat(i);
        step(1, 0, 0, 4'h0, 32'h0, 32'h0, 0, '0, '0);
        step(1, 1, 1, 4'hF, 32'h1234_5678, 32'h5555_AAAA, 1, 12'h123, 8'h4);
        // Core write then read-back of the same word.
        step(0, 1, 1, 4'hF, 32'h8010_0024, 32'hDEAD_BEEF, 0, '0, '0);
        step(0, 1, 0, 4'hF, 32'h8010_0024, 32'h0, 0, '0, '0);
        idle(2);
        step(0, 1, 1, 4'h5, 32'h0000_0038, 32'h1122_3344, 0, '0, '0);
        // Plain burst, then a burst wrapping past the last row.
        step(0, 0, 0, 4'h0, 32'h0, 32'h0, 1, 12'h010, 8'd3);
        idle(6);
        step(0, 0, 0, 4'h0, 32'h0, 32'h0, 1, 12'hFFE, 8'd3);
        idle(6);
        // Core held busy across a two-beat burst.
        step(0, 1, 0, 4'hF, 32'h0000_0048, 32'h0, 1, 12'h001, 8'd1);
        core_hold(4);
        idle(4);
        // Reset in the middle of a long burst, then an immediate new command.
        step(0, 0, 0, 4'h0, 32'h0, 32'h0, 1, 12'h020, 8'd7);
        idle(2);
        step(1, 0, 0, 4'h0, 32'h0, 32'h0, 0, '0, '0);
        step(0, 0, 0, 4'h0, 32'h0, 32'h0, 1, 12'h030, 8'd0);
        idle(3);
        // Core read and burst command in the same idle cycle.
        step(0, 1, 0, 4'hF, 32'h0000_0204, 32'h0, 1, 12'h010, 8'd2);
        idle(5);
        pend = 0; aa = '0; al = '0;
        for (int c = 0; c < 4000; c++) begin
            if (!pend && $urandom_range(0, 3) == 0) begin
                pend = 1;
                aa = ($urandom_range(0, 1) == 0) ? ROW_AW'($urandom_range(0, 15)) : ROW_AW'($urandom_range(4088, 4095));
                al = ($urandom_range(0, 15) == 0) ? LEN_W'($urandom) : LEN_W'($urandom_range(0, 5));
            end
            pa = $urandom;
            pa[ROW_AW+4:5] = ROW_AW'($urandom_range(0, 15));
            step($urandom_range(0, 299) == 0, $urandom_range(0, 2) == 0, $urandom_range(0, 1) == 1,
                 4'($urandom), pa, $urandom, pend, aa, al);
            if (last_agnt) pend = 0;
        end
        idle(2);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
